// File: rtl/sa_tile_ctrl_if.sv
// sa_tile_ctrl_if -- signal bundle between the tile sequencer, the command
// decoder, the global A/B/C buffers and the 4x4 systolic array.
//
//   command : start, m_tiles/k_tiles/n_tiles (in), busy/done (out)
//   A/B buf : a_addr/b_addr (out), a_data/b_data (in, 1-cycle read latency)
//   C buf   : c_wen/c_addr/c_data (out), c_data = {col0,col1,col2,col3}
//   array   : sa_rst_n, sa_a0..3, sa_b0..3 (out), sa_done, sa_c0..3 (in)
//
// modport master = sequencer side, modport slave = everything around it.
interface sa_tile_ctrl_if #(
    parameter int ADDR_BITS  = 16,
    parameter int DATA_BITS  = 32,
    parameter int DATAC_BITS = 128,
    parameter int DIM_BITS   = 8
);
    logic                  start;
    logic [DIM_BITS-1:0]   m_tiles, k_tiles, n_tiles;
    logic                  busy, done;
    logic [ADDR_BITS-1:0]  a_addr, b_addr, c_addr;
    logic [DATA_BITS-1:0]  a_data, b_data;
    logic                  c_wen;
    logic [DATAC_BITS-1:0] c_data;
    logic                  sa_rst_n, sa_done;
    logic [DATA_BITS-1:0]  sa_a0, sa_a1, sa_a2, sa_a3;
    logic [DATA_BITS-1:0]  sa_b0, sa_b1, sa_b2, sa_b3;
    logic [DATAC_BITS-1:0] sa_c0, sa_c1, sa_c2, sa_c3;

    modport master (
        input  start, m_tiles, k_tiles, n_tiles, a_data, b_data, sa_done,
               sa_c0, sa_c1, sa_c2, sa_c3,
        output busy, done, a_addr, b_addr, c_wen, c_addr, c_data, sa_rst_n,
               sa_a0, sa_a1, sa_a2, sa_a3, sa_b0, sa_b1, sa_b2, sa_b3
    );

    modport slave (
        output start, m_tiles, k_tiles, n_tiles, a_data, b_data, sa_done,
               sa_c0, sa_c1, sa_c2, sa_c3,
        input  busy, done, a_addr, b_addr, c_wen, c_addr, c_data, sa_rst_n,
               sa_a0, sa_a1, sa_a2, sa_a3, sa_b0, sa_b1, sa_b2, sa_b3
    );
endinterface

// File: rtl/sa_tile_ctrl.sv
// sa_tile_ctrl -- tiled C = A x B sequencer for the 4x4 int8 systolic array.
// For each output tile (row-major over m,n) it walks k: fetch the A/B tile
// (4 words each), arm and run the array, add the 4x4 partial product into
// 32-bit accumulators, and after the last k writes the C tile as 4 rows.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   sat_flag   : sticky accumulator-saturation flag (only with SA_ACC_SAT_EN)
//   bus        : sa_tile_ctrl_if.master (command, buffers, array)
//
// Build option: define SA_ACC_SAT_EN for signed saturating accumulation and
// the sat_flag output; otherwise accumulation wraps mod 2^32.
module sa_tile_ctrl #(
    parameter int ADDR_BITS  = 16,
    parameter int DATA_BITS  = 32,
    parameter int DATAC_BITS = 128,
    parameter int DIM_BITS   = 8
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SA_ACC_SAT_EN
    output logic sat_flag,
`endif
    sa_tile_ctrl_if.master bus
);
    localparam int LANE = DATAC_BITS / 4;

    typedef enum logic [2:0] {IDLE, LOAD, ARM, RUN, ACC, WRITE, NEXT, FIN} state_t;
    state_t state, state_nx;

    logic [DIM_BITS-1:0]         mt_q, kt_q, nt_q, m_q, n_q, k_q;
    logic [2:0]                  cnt_q;       // LOAD 0..4, WRITE 0..3
    logic [3:0][DATA_BITS-1:0]   sa_a_q, sa_b_q;
    logic [3:0][DATAC_BITS-1:0]  acc_q, acc_sum; // rows laid out like sa_c
    logic [3:0][DATAC_BITS-1:0]  sa_c;
    logic [ADDR_BITS-1:0]        a_hold_q, b_hold_q;
    logic [ADDR_BITS-1:0]        a_base, b_base, c_base, a_cur, b_cur;
    logic [1:0]                  ld_j;
    logic                        start_ok, zero_dim, last_k, last_n, last_m;
`ifdef SA_ACC_SAT_EN
    logic                        ovf_any;
`endif

    assign sa_c     = {bus.sa_c3, bus.sa_c2, bus.sa_c1, bus.sa_c0};
    assign start_ok = (state == IDLE) && bus.start;
    assign zero_dim = (bus.m_tiles == '0) || (bus.k_tiles == '0) || (bus.n_tiles == '0);
    assign last_k   = (k_q + DIM_BITS'(1)) == kt_q;
    assign last_n   = (n_q + DIM_BITS'(1)) == nt_q;
    assign last_m   = (m_q + DIM_BITS'(1)) == mt_q;

    // Tile base addresses, truncated to the buffer address width.
    assign a_base = ADDR_BITS'(((32'(m_q) * 32'(kt_q)) + 32'(k_q)) << 2);
    assign b_base = ADDR_BITS'(((32'(k_q) * 32'(nt_q)) + 32'(n_q)) << 2);
    assign c_base = ADDR_BITS'(((32'(m_q) * 32'(nt_q)) + 32'(n_q)) << 2);

    // LOAD cycle 4 only captures the last word; keep presenting word 3.
    assign ld_j  = (cnt_q > 3'd3) ? 2'd3 : cnt_q[1:0];
    assign a_cur = a_base + ADDR_BITS'(ld_j);
    assign b_cur = b_base + ADDR_BITS'(ld_j);

    // Addresses hold their last fetched value outside LOAD.
    assign bus.a_addr   = (state == LOAD) ? a_cur : a_hold_q;
    assign bus.b_addr   = (state == LOAD) ? b_cur : b_hold_q;
    assign bus.busy     = (state != IDLE) && (state != FIN);
    assign bus.done     = (state == FIN);
    assign bus.sa_rst_n = (state == RUN);
    assign bus.c_wen    = (state == WRITE);
    assign bus.c_addr   = (state == WRITE) ? c_base + ADDR_BITS'(cnt_q[1:0]) : '0;
    assign bus.c_data   = (state == WRITE) ? acc_q[cnt_q[1:0]] : '0;
    assign bus.sa_a0 = sa_a_q[0];
    assign bus.sa_a1 = sa_a_q[1];
    assign bus.sa_a2 = sa_a_q[2];
    assign bus.sa_a3 = sa_a_q[3];
    assign bus.sa_b0 = sa_b_q[0];
    assign bus.sa_b1 = sa_b_q[1];
    assign bus.sa_b2 = sa_b_q[2];
    assign bus.sa_b3 = sa_b_q[3];

    // Lane-wise accumulate of the array result into the accumulator rows.
    always_comb begin
        logic [LANE-1:0] x, y, s;
        logic            ovf;
        acc_sum = acc_q;
        x = '0;
        y = '0;
        s = '0;
        ovf = 1'b0;
`ifdef SA_ACC_SAT_EN
        ovf_any = 1'b0;
`endif
        for (int r = 0; r < 4; r++) begin
            for (int l = 0; l < 4; l++) begin
                x   = acc_q[r][l*LANE +: LANE];
                y   = sa_c[r][l*LANE +: LANE];
                s   = x + y;
                ovf = (x[LANE-1] == y[LANE-1]) && (s[LANE-1] != x[LANE-1]);
`ifdef SA_ACC_SAT_EN
                if (ovf)
                    s = x[LANE-1] ? {1'b1, {(LANE-1){1'b0}}} : {1'b0, {(LANE-1){1'b1}}};
                ovf_any = ovf_any | ovf;
`endif
                acc_sum[r][l*LANE +: LANE] = s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (bus.start) state_nx = zero_dim ? FIN : LOAD;
            LOAD:  if (cnt_q == 3'd4) state_nx = ARM;
            ARM:   state_nx = RUN;
            RUN:   if (bus.sa_done) state_nx = ACC;
            ACC:   state_nx = last_k ? WRITE : LOAD;
            WRITE: if (cnt_q == 3'd3) state_nx = NEXT;
            NEXT:  state_nx = (last_m && last_n) ? FIN : LOAD;
            FIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mt_q     <= '0;
            kt_q     <= '0;
            nt_q     <= '0;
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            sa_a_q   <= '0;
            sa_b_q   <= '0;
            acc_q    <= '0;
            a_hold_q <= '0;
            b_hold_q <= '0;
`ifdef SA_ACC_SAT_EN
            sat_flag <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start_ok) begin
                    mt_q  <= bus.m_tiles;
                    kt_q  <= bus.k_tiles;
                    nt_q  <= bus.n_tiles;
                    m_q   <= '0;
                    n_q   <= '0;
                    k_q   <= '0;
                    cnt_q <= '0;
                    acc_q <= '0;
`ifdef SA_ACC_SAT_EN
                    sat_flag <= 1'b0;
`endif
                end
                LOAD: begin
                    a_hold_q <= a_cur;
                    b_hold_q <= b_cur;
                    // Word j returns one cycle after its address: cnt 1..4 -> j 0..3.
                    if (cnt_q != 3'd0) begin
                        sa_a_q[cnt_q[1:0] - 2'd1] <= bus.a_data;
                        sa_b_q[cnt_q[1:0] - 2'd1] <= bus.b_data;
                    end
                    cnt_q <= (cnt_q == 3'd4) ? 3'd0 : cnt_q + 3'd1;
                end
                ACC: begin
                    acc_q <= acc_sum;
                    if (!last_k) k_q <= k_q + DIM_BITS'(1);
`ifdef SA_ACC_SAT_EN
                    if (ovf_any) sat_flag <= 1'b1;
`endif
                end
                WRITE: cnt_q <= (cnt_q == 3'd3) ? 3'd0 : cnt_q + 3'd1;
                NEXT: begin
                    acc_q <= '0;
                    k_q   <= '0;
                    if (last_n) begin
                        n_q <= '0;
                        m_q <= m_q + DIM_BITS'(1);
                    end else begin
                        n_q <= n_q + DIM_BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sa_tile_ctrl.sv
// tb_sa_tile_ctrl -- directed bench for sa_tile_ctrl with a behavioural A/B
// buffer, a behavioural 4x4 array (optionally fed injected results), and a
// scoreboard of expected C writes popped on every c_wen.
module tb_sa_tile_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sa_tile_ctrl_if bus ();
`ifdef SA_ACC_SAT_EN
    logic sat_flag;
`endif

    sa_tile_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef SA_ACC_SAT_EN
        .sat_flag (sat_flag),
`endif
        .bus      (bus)
    );

    typedef struct packed {
        logic [15:0]  addr;
        logic [127:0] data;
    } cwr_t;

    int tests = 0;
    int fails = 0;
    logic [31:0]  a_mem [256];
    logic [31:0]  b_mem [256];
    cwr_t         exp_q [$];
    logic [127:0] inj_q [$];
    int           a_log [$];
    int           b_log [$];
    int           n_wen, n_done, n_runs, last_a, last_b, lat;
    logic         prev_sarst;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // signed int8 lane i of a word, lane 0 in the MSBs
    function automatic int sb(input logic [31:0] w, input int i);
        logic [7:0] b;
        b = w[8*(3-i) +: 8];
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [127:0] arr_row(input logic [3:0][31:0] a,
                                             input logic [3:0][31:0] b, input int r);
        logic [127:0] row;
        int s;
        row = '0;
        for (int c = 0; c < 4; c++) begin
            s = 0;
            for (int i = 0; i < 4; i++) s += sb(a[r], i) * sb(b[i], c);
            row[32*(3-c) +: 32] = s;
        end
        return row;
    endfunction

    // Reference C for the whole job, pushed in row-major tile order.
    task automatic push_ref(input int mt, input int kt, input int nt);
        int s [4];
        cwr_t e;
        for (int tm = 0; tm < mt; tm++)
            for (int tn = 0; tn < nt; tn++)
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) s[c] = 0;
                    for (int tk = 0; tk < kt; tk++)
                        for (int i = 0; i < 4; i++)
                            for (int c = 0; c < 4; c++)
                                s[c] += sb(a_mem[(tm*kt+tk)*4+r], i) * sb(b_mem[(tk*nt+tn)*4+i], c);
                    e.addr = 16'((tm*nt+tn)*4+r);
                    e.data = {s[0], s[1], s[2], s[3]};
                    exp_q.push_back(e);
                end
    endtask

    task automatic push_exp(input int addr, input logic [127:0] data);
        cwr_t e;
        e.addr = 16'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    // A/B buffers: registered read, one cycle latency
    always @(posedge clk) begin
        bus.a_data <= a_mem[bus.a_addr[7:0]];
        bus.b_data <= b_mem[bus.b_addr[7:0]];
    end

    // Array: result 3 cycles into RUN, held until sa_rst_n drops
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !bus.sa_rst_n) begin
            bus.sa_done <= 1'b0;
            lat <= 0;
            bus.sa_c0 <= '0;
            bus.sa_c1 <= '0;
            bus.sa_c2 <= '0;
            bus.sa_c3 <= '0;
        end else if (!bus.sa_done) begin
            lat <= lat + 1;
            if (lat == 2) begin
                bus.sa_done <= 1'b1;
                if (inj_q.size() >= 4) begin
                    bus.sa_c0 <= inj_q[0];
                    bus.sa_c1 <= inj_q[1];
                    bus.sa_c2 <= inj_q[2];
                    bus.sa_c3 <= inj_q[3];
                    repeat (4) inj_q.delete(0);
                end else begin
                    bus.sa_c0 <= arr_row({bus.sa_a3, bus.sa_a2, bus.sa_a1, bus.sa_a0},
                                         {bus.sa_b3, bus.sa_b2, bus.sa_b1, bus.sa_b0}, 0);
                    bus.sa_c1 <= arr_row({bus.sa_a3, bus.sa_a2, bus.sa_a1, bus.sa_a0},
                                         {bus.sa_b3, bus.sa_b2, bus.sa_b1, bus.sa_b0}, 1);
                    bus.sa_c2 <= arr_row({bus.sa_a3, bus.sa_a2, bus.sa_a1, bus.sa_a0},
                                         {bus.sa_b3, bus.sa_b2, bus.sa_b1, bus.sa_b0}, 2);
                    bus.sa_c3 <= arr_row({bus.sa_a3, bus.sa_a2, bus.sa_a1, bus.sa_a0},
                                         {bus.sa_b3, bus.sa_b2, bus.sa_b1, bus.sa_b0}, 3);
                end
            end
        end
    end

    // Monitor: scoreboard on C writes, pulse/pass counts, fetch address log
    initial begin
        cwr_t e;
        prev_sarst = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.c_wen === 1'b1) begin
                n_wen++;
                if (exp_q.size() == 0) chk("c_unexpected", {bus.c_addr, bus.c_data}, '0);
                else begin
                    e = exp_q.pop_front();
                    chk("c_addr", bus.c_addr, e.addr);
                    chk("c_data", bus.c_data, e.data);
                end
            end
            if (bus.done === 1'b1) n_done++;
            if (bus.sa_rst_n === 1'b1 && !prev_sarst) n_runs++;
            prev_sarst = bus.sa_rst_n;
            if (bus.busy === 1'b1) begin
                if (int'(bus.a_addr) != last_a) begin a_log.push_back(int'(bus.a_addr)); last_a = int'(bus.a_addr); end
                if (int'(bus.b_addr) != last_b) begin b_log.push_back(int'(bus.b_addr)); last_b = int'(bus.b_addr); end
            end
        end
    end

    task automatic clear_stats();
        n_wen = 0; n_done = 0; n_runs = 0; last_a = -1; last_b = -1;
        a_log.delete(); b_log.delete();
    endtask

    task automatic do_start(input int m, input int k, input int n);
        @(negedge clk);
        clear_stats();
        bus.start = 1'b1;
        bus.m_tiles = 8'(m);
        bus.k_tiles = 8'(k);
        bus.n_tiles = 8'(n);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (bus.done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done"}, bus.done, 1'b1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, {bus.busy, bus.done, bus.c_wen, bus.sa_rst_n}, '0);
        chk({tag, "_addr"}, {bus.a_addr, bus.b_addr, bus.c_addr}, '0);
        chk({tag, "_cdata"}, bus.c_data, '0);
        chk({tag, "_sa"}, |{bus.sa_a0, bus.sa_a1, bus.sa_a2, bus.sa_a3,
                            bus.sa_b0, bus.sa_b1, bus.sa_b2, bus.sa_b3}, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        bus.start = 1'b0;
        bus.m_tiles = '0;
        bus.k_tiles = '0;
        bus.n_tiles = '0;
        clear_stats();
        for (int i = 0; i < 256; i++) begin a_mem[i] = '0; b_mem[i] = '0; end

        // reset state
        repeat (2) @(negedge clk);
        chk_reset("por");
        rst_n = 1'b1;

        // zero dimension: done next cycle, no array activity, no writes
        do_start(1, 0, 1);
        chk("t4_done_next", {bus.done, bus.busy}, 2'b10);
        chk("t4_sa_rst", bus.sa_rst_n, 1'b0);
        // start during the done cycle is ignored
        bus.start = 1'b1; bus.k_tiles = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("t4_start_in_done", {bus.busy, bus.done}, 2'b00);
        chk("t4_no_access", {n_wen[7:0], n_runs[7:0], bus.a_addr, bus.b_addr}, '0);

        // identity A times B, with a start pulse while busy
        a_mem[0] = 32'h01000000; a_mem[1] = 32'h00010000;
        a_mem[2] = 32'h00000100; a_mem[3] = 32'h00000001;
        b_mem[0] = 32'h01020304; b_mem[1] = 32'h05060708;
        b_mem[2] = 32'h090A0B0C; b_mem[3] = 32'h0D0E0F10;
        push_exp(0, {32'd1, 32'd2, 32'd3, 32'd4});
        push_exp(1, {32'd5, 32'd6, 32'd7, 32'd8});
        push_exp(2, {32'd9, 32'd10, 32'd11, 32'd12});
        push_exp(3, {32'd13, 32'd14, 32'd15, 32'd16});
        do_start(1, 1, 1);
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.m_tiles = 8'd2; bus.k_tiles = 8'd2; bus.n_tiles = 8'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("t1");
        @(negedge clk);
        chk("t1_wen_cnt", n_wen, 4);
        chk("t1_done_cnt", n_done, 1);
        chk("t1_left", exp_q.size(), 0);

        // K walk: all ones, 3 passes
        for (int i = 0; i < 12; i++) begin a_mem[i] = 32'h01010101; b_mem[i] = 32'h01010101; end
        for (int r = 0; r < 4; r++) push_exp(r, {4{32'd12}});
        do_start(1, 3, 1);
        wait_done("t2");
        chk("t2_runs", n_runs, 3);
        chk("t2_alog_len", a_log.size(), 12);
        chk("t2_blog_len", b_log.size(), 12);
        for (int i = 0; i < 12 && i < a_log.size() && i < b_log.size(); i++) begin
            chk("t2_a_order", a_log[i], i);
            chk("t2_b_order", b_log[i], i);
        end
        chk("t2_left", exp_q.size(), 0);

        // 2x1x2 distinct tiles, row-major tile order
        for (int i = 0; i < 16; i++) begin a_mem[i] = $urandom; b_mem[i] = $urandom; end
        push_ref(2, 1, 2);
        do_start(2, 1, 2);
        wait_done("t3");
        chk("t3_wen_cnt", n_wen, 16);
        chk("t3_left", exp_q.size(), 0);

        // reset during WRITE row 1 of a 2x2x2 job, then rerun
        for (int i = 0; i < 32; i++) begin a_mem[i] = $urandom; b_mem[i] = $urandom; end
        push_ref(2, 2, 2);
        do_start(2, 2, 2);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!(bus.c_wen === 1'b1 && bus.c_addr == 16'd1) && cyc < 3000);
        chk("t5_reach_row1", {bus.c_wen, bus.c_addr}, {1'b1, 16'd1});
        #1 rst_n = 1'b0;
        #1 chk_reset("t5_mid");
        @(negedge clk);
        chk("t5_wen_cnt", n_wen, 1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_ref(2, 2, 2);
        do_start(2, 2, 2);
        wait_done("t5_rerun");
        chk("t5_rerun_wen", n_wen, 16);
        chk("t5_left", exp_q.size(), 0);

        // accumulator overflow with injected array results
        inj_q.push_back({32'h7FFF0000, 32'd1, 32'd0, 32'd0});
        inj_q.push_back({32'd1, 32'd2, 32'd3, 32'd4});
        inj_q.push_back({32'd0, 32'h80000000, 32'd0, 32'd0});
        inj_q.push_back({4{32'd0}});
        inj_q.push_back({32'h00020000, 32'd1, 32'd0, 32'd0});
        inj_q.push_back({32'd5, 32'd6, 32'd7, 32'd8});
        inj_q.push_back({32'd0, 32'hFFFFFFFF, 32'd0, 32'd0});
        inj_q.push_back({4{32'hFFFFFFFF}});
`ifdef SA_ACC_SAT_EN
        push_exp(0, {32'h7FFFFFFF, 32'd2, 32'd0, 32'd0});
        push_exp(1, {32'd6, 32'd8, 32'd10, 32'd12});
        push_exp(2, {32'd0, 32'h80000000, 32'd0, 32'd0});
        push_exp(3, {4{32'hFFFFFFFF}});
`else
        push_exp(0, {32'h80010000, 32'd2, 32'd0, 32'd0});
        push_exp(1, {32'd6, 32'd8, 32'd10, 32'd12});
        push_exp(2, {32'd0, 32'h7FFFFFFF, 32'd0, 32'd0});
        push_exp(3, {4{32'hFFFFFFFF}});
`endif
        do_start(1, 2, 1);
        wait_done("t6");
        chk("t6_left", exp_q.size(), 0);
        chk("t6_inj_used", inj_q.size(), 0);
`ifdef SA_ACC_SAT_EN
        chk("t6_sat_flag", sat_flag, 1'b1);
        do_start(1, 0, 1);
        chk("t6_sat_clear", sat_flag, 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sa_tile_ctrl.md
Name: sa_tile_ctrl

Overview:
Tiled matrix-multiply sequencer for the 4x4 int8 systolic array. It computes C = A x B for operands sized in 4x4 tiles. For each output tile it walks the K dimension:
- fetches A and B tiles from the global operand buffers,
- arms and runs the array,
- accumulates each 4x4 partial product in 32-bit registers,
- writes the finished C tile back as four 128-bit rows.

It sits between the CFU command decoder (start/done) and the systolic array plus its global buffers.

Parameters:
ADDR_BITS, 16, global buffer address width
DATA_BITS, 32, A/B word width (four int8 lanes)
DATAC_BITS, 128, C row width (four 32-bit results)
DIM_BITS, 8, width of each tile-count input

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
m_tiles  in  DIM_BITS  rows of C in tiles (M_T)
k_tiles  in  DIM_BITS  inner dimension in tiles (K_T)
n_tiles  in  DIM_BITS  columns of C in tiles (N_T)
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the job completes
a_addr  out  ADDR_BITS  A buffer read address
a_data  in  DATA_BITS  A read data, valid 1 cycle after a_addr
b_addr  out  ADDR_BITS  B buffer read address
b_data  in  DATA_BITS  B read data, valid 1 cycle after b_addr
c_wen  out  1  C buffer write strobe
c_addr  out  ADDR_BITS  C write address
c_data  out  DATAC_BITS  C write row, {col0,col1,col2,col3}, col0 in MSBs
sa_rst_n  out  1  array reset/arm, active low
sa_done  in  1  array completion indication
sa_a0..sa_a3  out  DATA_BITS each  A tile words to the array
sa_b0..sa_b3  out  DATA_BITS each  B tile words to the array
sa_c0..sa_c3  in  DATAC_BITS each  array result rows

Behaviour:
- Reset values: busy=0, done=0, c_wen=0, sa_rst_n=0; all addresses, c_data, sa_a*/sa_b* and accumulators = 0; state IDLE.
- Address map, all tiles in array-native word format, j = 0..3:
  - A word: ((m*K_T+k)*4+j)
  - B word: ((k*N_T+n)*4+j)
  - C row r: ((m*N_T+n)*4+r)
- Dimension inputs are captured on an accepted start and ignored afterwards.
- FSM states: IDLE, LOAD, ARM, RUN, ACC, WRITE, NEXT, FIN.
- IDLE: sa_rst_n=0.
  - On start with any dimension = 0: go to FIN with no memory access.
  - On start otherwise: clear m, n, k and accumulators, go to LOAD.
- LOAD, 5 cycles: issue a_addr/b_addr for j = 0..3 on cycles 0..3. Capture data one cycle later into sa_a[j]/sa_b[j].
- sa_a*/sa_b* stay stable from end of LOAD until leaving RUN.
- ARM, 1 cycle: sa_rst_n held 0 so the array latches its operands. Then go to RUN.
- RUN: sa_rst_n=1. Wait for sa_done=1 (sampled at posedge), then go to ACC with sa_rst_n=0. No timeout in base build.
- ACC, 1 cycle:
  - acc[r][c] += sa_c_r[31+32*(3-c) : 32*(3-c)], 32-bit two's complement, wraps mod 2^32.
  - If k < K_T-1: k++, go to LOAD.
  - Else go to WRITE.
- WRITE, 4 cycles: c_wen=1, c_addr = C row r, c_data = acc row r, for r = 0..3.
- NEXT:
  - Clear acc and k.
  - Advance n; when n wraps, advance m.
  - Go to LOAD, or to FIN after tile (M_T-1, N_T-1).
- FIN: done=1 for one cycle, busy falls in the same cycle, go to IDLE.
- Output-tile order is row-major over (m, n).
- start while busy is ignored.
- start asserted in the same cycle done pulses is ignored; a new start is accepted from IDLE on the next cycle.
- Reset mid-operation: immediate return to reset values. No C write completes after rst_n falls. The array is held reset via sa_rst_n=0.
- Address arithmetic is truncated to ADDR_BITS; callers guarantee the footprint fits.

Optional Feature:
- Macro SA_ACC_SAT_EN.
- When defined, ACC adds signed saturating: result clamps to 0x7FFFFFFF or 0x80000000 on overflow, and a sticky output sat_flag (1 bit, reset 0, cleared on accepted start) is set.
- When undefined, the add wraps and the sat_flag port does not exist.

Test Plan:
1. M_T=K_T=N_T=1, A = identity (words 0x01000000, 0x00010000, 0x00000100, 0x00000001), B words 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10 -> C rows at addr 0..3 = {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16} as 32-bit lanes. Exactly 4 c_wen pulses, one done pulse.
2. M_T=1, K_T=3, N_T=1, every A/B byte = 1 -> each C element = 12. Three ARM/RUN passes. A addresses 0..11 and B addresses 0..11 read in order.
3. M_T=2, K_T=1, N_T=2 with distinct tiles -> C tiles written in order (0,0), (0,1), (1,0), (1,1) at base 0, 4, 8, 12. Values match the reference model.
4. start with k_tiles=0 -> done one cycle later, zero memory accesses, sa_rst_n stays 0.
5. rst_n dropped during WRITE row 1 of a 2x2x2 job -> c_wen=0 immediately, all outputs at reset values. A fresh start then completes correctly.
6. SA_ACC_SAT_EN defined, K_T=2, partial sums pushing an element past 0x7FFFFFFF -> element reads 0x7FFFFFFF, sat_flag=1. Without the macro the same element wraps to the modular sum.
